// File: rtl/pe_spike_conv_row_if.sv
// Handshake bundle for one spiking-conv PE: filter load, spike-row input,
// partial-sum output and spike-row forward to the next PE in the column.
interface pe_spike_conv_row_if #(
  parameter int K       = 3,
  parameter int IFMAP_W = 5,
  parameter int WT_W    = 8,
  parameter int PSUM_W  = 10,
  parameter int IDX_W   = ((IFMAP_W - K + 1) > 1) ? $clog2(IFMAP_W - K + 1) : 1
);
  logic                 filt_valid;
  logic                 filt_ready;
  logic [K*WT_W-1:0]    filt_data;

  logic                 ifmap_valid;
  logic                 ifmap_ready;
  logic [IFMAP_W-1:0]   ifmap_data;

  logic                 psum_valid;
  logic                 psum_ready;
  logic [PSUM_W-1:0]    psum_data;
  logic [IDX_W-1:0]     psum_idx;
  logic                 psum_last;

  logic                 fwd_valid;
  logic                 fwd_ready;
  logic [IFMAP_W-1:0]   fwd_data;

  // Upstream producer / downstream consumer side.
  modport master (
    output filt_valid, filt_data, ifmap_valid, ifmap_data, psum_ready, fwd_ready,
    input  filt_ready, ifmap_ready, psum_valid, psum_data, psum_idx, psum_last,
           fwd_valid, fwd_data
  );

  // Processing-element side.
  modport slave (
    input  filt_valid, filt_data, ifmap_valid, ifmap_data, psum_ready, fwd_ready,
    output filt_ready, ifmap_ready, psum_valid, psum_data, psum_idx, psum_last,
           fwd_valid, fwd_data
  );
endinterface

// File: rtl/pe_spike_conv_row.sv
// Spiking 1-D convolution PE: one spike-gated weight tap per cycle into a
// saturating accumulator, NOUT sliding sums per row, optional row forward.
module pe_spike_conv_row #(
  parameter int K         = 3,
  parameter int IFMAP_W   = 5,
  parameter int WT_W      = 8,
  parameter int PSUM_W    = 10,
  parameter int FWD_IFMAP = 1
) (
  input  logic               clk,
  input  logic               rst,
  pe_spike_conv_row_if.slave bus,
  output logic               busy
);

  localparam int NOUT  = IFMAP_W - K + 1;
  localparam int IDX_W = (NOUT > 1) ? $clog2(NOUT) : 1;
  localparam int TAP_W = (K > 1) ? $clog2(K) : 1;
  localparam int SUM_W = ((WT_W > PSUM_W) ? WT_W : PSUM_W) + 1;
  localparam logic [SUM_W-1:0] PSUM_MAX = SUM_W'({PSUM_W{1'b1}});

  typedef enum logic [1:0] {IDLE, MAC, OUT, FWD} state_t;

  state_t              state, next_state;
  logic                filt_loaded;
  logic [K*WT_W-1:0]   wts;
  logic [IFMAP_W-1:0]  row;
  logic [PSUM_W-1:0]   acc;
  logic [IDX_W-1:0]    j;
  logic [TAP_W-1:0]    tap;

  logic                filt_ready, ifmap_ready, psum_valid, fwd_valid;
  logic                filt_accept, ifmap_accept, psum_fire;
  logic                tap_last, j_last;

  logic [WT_W-1:0]     tap_wt;
  logic                spike_bit;
  logic [SUM_W-1:0]    sum;
  logic [PSUM_W-1:0]   acc_next;

  assign tap_last     = (tap == TAP_W'(K - 1));
  assign j_last       = (j == IDX_W'(NOUT - 1));
  assign filt_accept  = bus.filt_valid && filt_ready;
  assign ifmap_accept = bus.ifmap_valid && ifmap_ready;
  assign psum_fire    = psum_valid && bus.psum_ready;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every register samples pre-edge values, independent of block order.
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    next_state  = state;
    filt_ready  = 1'b0;
    ifmap_ready = 1'b0;
    psum_valid  = 1'b0;
    fwd_valid   = 1'b0;
    case (state)
      IDLE: begin
        filt_ready = 1'b1;
        // A pending filter wins, so filter and row never land in the same cycle.
        ifmap_ready = filt_loaded && !bus.filt_valid;
        if (bus.ifmap_valid && ifmap_ready) next_state = MAC;
      end
      MAC: begin
        if (tap_last) next_state = OUT;
      end
      OUT: begin
        psum_valid = 1'b1;
        if (bus.psum_ready) begin
          if (!j_last)             next_state = MAC;
          else if (FWD_IFMAP != 0) next_state = FWD;
          else                     next_state = IDLE;
        end
      end
      FWD: begin
        fwd_valid = (FWD_IFMAP != 0);
        if (bus.fwd_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Multiply-free tap: the spike bit under the window gates its weight in.
  always_comb begin
    tap_wt    = WT_W'(wts >> (int'(tap) * WT_W));
    spike_bit = 1'(row >> (int'(j) + int'(tap)));
    sum       = SUM_W'(acc) + (spike_bit ? SUM_W'(tap_wt) : '0);
    acc_next  = (sum > PSUM_MAX) ? '1 : PSUM_W'(sum);
  end

  // NOTE: the weight row is storage gated by filt_loaded, so it needs no reset.
  always_ff @(posedge clk) begin
    if (filt_accept) wts <= bus.filt_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_loaded <= 1'b0;
      row         <= '0;
      acc         <= '0;
      j           <= '0;
      tap         <= '0;
    end else begin
      if (filt_accept) filt_loaded <= 1'b1;
      if (ifmap_accept) begin
        row <= bus.ifmap_data;
        acc <= '0;
        j   <= '0;
        tap <= '0;
      end
      if (state == MAC) begin
        acc <= acc_next;
        tap <= tap_last ? '0 : tap + TAP_W'(1);
      end
      if (psum_fire && !j_last) begin
        j   <= j + IDX_W'(1);
        acc <= '0;
        tap <= '0;
      end
    end
  end

  // acc, j and row are frozen outside MAC/accept, so OUT and FWD hold stable.
  assign bus.filt_ready  = filt_ready;
  assign bus.ifmap_ready = ifmap_ready;
  assign bus.psum_valid  = psum_valid;
  assign bus.psum_data   = acc;
  assign bus.psum_idx    = j;
  assign bus.psum_last   = psum_valid && j_last;
  assign bus.fwd_valid   = fwd_valid;
  assign bus.fwd_data    = row;
  assign busy            = (state != IDLE);

endmodule
